// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the LEGv8 ALU control decoder: ALU select codes,
// opcode constants, the decoded control bundle and the combinational decode.
`timescale 1ns/1ps

package alu_ctrl_pkg;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_XOR = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;

    typedef struct packed {
        logic [3:0] sel;
        logic       alu_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       reg_wr;
        logic       illegal;
    } ctrl_bundle_t;

    // CBZ is identified by its 8-bit opcode; everything else by the 11-bit
    // field. Unsupported words (ORR included) become an inert illegal bundle.
    function automatic ctrl_bundle_t decode(input logic [31:0] instr);
        ctrl_bundle_t b;
        b = '0;
        if (instr[31:24] == OP_CBZ) begin
            b.sel    = SEL_SUB;
            b.branch = 1'b1;
        end else begin
            case (instr[31:21])
                OP_ADD: begin
                    b.sel    = SEL_ADD;
                    b.reg_wr = 1'b1;
                end
                OP_SUB: begin
                    b.sel    = SEL_SUB;
                    b.reg_wr = 1'b1;
                end
                OP_AND: begin
                    b.sel    = SEL_AND;
                    b.reg_wr = 1'b1;
                end
                OP_EOR: begin
                    b.sel    = SEL_XOR;
                    b.reg_wr = 1'b1;
                end
                OP_LDUR: begin
                    b.sel     = SEL_ADD;
                    b.alu_src = 1'b1;
                    b.mem_rd  = 1'b1;
                    b.reg_wr  = 1'b1;
                end
                OP_STUR: begin
                    b.sel     = SEL_ADD;
                    b.alu_src = 1'b1;
                    b.mem_wr  = 1'b1;
                end
                default: begin
                    b.illegal = 1'b1;
                end
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder_skid.sv
// Registered valid/ready stage for the decoded bundle (module ctrl_skid_buf).
// Default: main + skid register, s_ready comes straight from a flop.
// With ALU_CTRL_BYPASS_EN defined: main register only, s_ready is
// combinational from m_ready.
`timescale 1ns/1ps

module ctrl_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         s_accept;
    logic         main_free;

    assign m_valid   = main_valid;
    assign m_data    = main_data;
    assign s_accept  = s_valid && s_ready;
    assign main_free = !main_valid || m_ready;

`ifdef ALU_CTRL_BYPASS_EN

    assign s_ready = main_free;

    // Single register: load whenever the consumer frees it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
        end else if (main_free) begin
            main_valid <= s_accept;
            if (s_accept) begin
                main_data <= s_data;
            end
        end
    end

`else

    logic         skid_valid;
    logic [W-1:0] skid_data;

    // s_ready is the inverse of a flop output, so no path from m_ready.
    assign s_ready = !skid_valid;

    // Main refills from skid first; s-side can only be accepted when skid
    // is empty, so a skid->main move never coincides with an accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= s_accept;
                if (s_accept) begin
                    main_data <= s_data;
                end
            end
        end else if (s_accept) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end

`endif

endmodule

// File: rtl/alu_ctrl_decoder.sv
// LEGv8 instruction -> ALU select / datapath control decoder with a
// registered valid/ready output stage and a saturating illegal counter.
// Build option: ALU_CTRL_BYPASS_EN removes the skid register (see
// ctrl_skid_buf).
`timescale 1ns/1ps

module alu_ctrl_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [INSTR_W-1:0] s_instr,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [SEL_W-1:0]   m_alu_sel,
    output logic               m_alu_src,
    output logic               m_mem_rd,
    output logic               m_mem_wr,
    output logic               m_branch,
    output logic               m_reg_wr,
    output logic               m_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam int BW = $bits(ctrl_bundle_t);

    ctrl_bundle_t  dec_b;
    ctrl_bundle_t  out_b;
    logic [BW-1:0] out_vec;

    assign dec_b = decode(s_instr);

    ctrl_skid_buf #(.W(BW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (dec_b),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (out_vec)
    );

    assign out_b     = ctrl_bundle_t'(out_vec);
    assign m_alu_sel = out_b.sel;
    assign m_alu_src = out_b.alu_src;
    assign m_mem_rd  = out_b.mem_rd;
    assign m_mem_wr  = out_b.mem_wr;
    assign m_branch  = out_b.branch;
    assign m_reg_wr  = out_b.reg_wr;
    assign m_illegal = out_b.illegal;

    // Count accepted illegal words, holding at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (s_valid && s_ready && dec_b.illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
`timescale 1ns/1ps

module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_instr;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_alu_sel;
    logic        m_alu_src, m_mem_rd, m_mem_wr, m_branch, m_reg_wr, m_illegal;
    logic [7:0]  illegal_cnt;

    int vectors = 0;
    int miscompares = 0;

    // {valid, sel[3:0], alu_src, mem_rd, mem_wr, branch, reg_wr, illegal}
    localparam logic [10:0] B_ADD  = {1'b1, 4'b0010, 6'b000010};
    localparam logic [10:0] B_SUB  = {1'b1, 4'b0110, 6'b000010};
    localparam logic [10:0] B_AND  = {1'b1, 4'b0000, 6'b000010};
    localparam logic [10:0] B_EOR  = {1'b1, 4'b0001, 6'b000010};
    localparam logic [10:0] B_LDUR = {1'b1, 4'b0010, 6'b110010};
    localparam logic [10:0] B_STUR = {1'b1, 4'b0010, 6'b101000};
    localparam logic [10:0] B_CBZ  = {1'b1, 4'b0110, 6'b000100};
    localparam logic [10:0] B_ORR  = {1'b1, 4'b0000, 6'b000001};

    localparam logic [31:0] W_ADD  = 32'h8B020020;
    localparam logic [31:0] W_SUB  = 32'hCB000000;
    localparam logic [31:0] W_AND  = 32'h8A000000;
    localparam logic [31:0] W_EOR  = 32'hCA000000;
    localparam logic [31:0] W_LDUR = 32'hF8400000;
    localparam logic [31:0] W_STUR = 32'hF8000000;
    localparam logic [31:0] W_CBZ  = 32'hB4000040;
    localparam logic [31:0] W_ORR  = 32'hAA020020;

    alu_ctrl_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_instr     (s_instr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_alu_sel   (m_alu_sel),
        .m_alu_src   (m_alu_src),
        .m_mem_rd    (m_mem_rd),
        .m_mem_wr    (m_mem_wr),
        .m_branch    (m_branch),
        .m_reg_wr    (m_reg_wr),
        .m_illegal   (m_illegal),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] obs_bundle();
        return {m_valid, m_alu_sel, m_alu_src, m_mem_rd, m_mem_wr, m_branch, m_reg_wr, m_illegal};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_instr = '0;
        m_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        chk("rst_bundle", 32'(obs_bundle()), 32'd0);

        // Single ADD, latency 1
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_instr = W_ADD;
        step();
        s_valid = 1'b0;
        chk("add_bundle", 32'(obs_bundle()), 32'(B_ADD));
        step();
        chk("add_drained", 32'(m_valid), 32'd0);

`ifndef ALU_CTRL_BYPASS_EN
        chk("idle_s_ready", 32'(s_ready), 32'd1);
`endif

        // Back-to-back LDUR, STUR, CBZ
        s_valid = 1'b1;
        s_instr = W_LDUR;
        step();
        chk("b2b_ldur", 32'(obs_bundle()), 32'(B_LDUR));
        s_instr = W_STUR;
        step();
        chk("b2b_stur", 32'(obs_bundle()), 32'(B_STUR));
        s_instr = W_CBZ;
        step();
        chk("b2b_cbz", 32'(obs_bundle()), 32'(B_CBZ));
        s_valid = 1'b0;
        step();
        chk("b2b_end", 32'(m_valid), 32'd0);

`ifndef ALU_CTRL_BYPASS_EN
        // Stall with three EOR words offered: two accepted, then s_ready low
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_instr = W_EOR;
        step();
        chk("eor_main", 32'(obs_bundle()), 32'(B_EOR));
        chk("eor_rdy1", 32'(s_ready), 32'd1);
        step();
        chk("eor_rdy2", 32'(s_ready), 32'd0);
        chk("eor_hold1", 32'(obs_bundle()), 32'(B_EOR));
        step();
        chk("eor_rdy3", 32'(s_ready), 32'd0);
        chk("eor_hold2", 32'(obs_bundle()), 32'(B_EOR));
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        chk("eor_drain1", 32'(obs_bundle()), 32'(B_EOR));
        chk("eor_rdy4", 32'(s_ready), 32'd1);
        step();
        chk("eor_drain_end", 32'(m_valid), 32'd0);

        // Stall with distinct words to check drain order
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_instr = W_AND;
        step();
        s_instr = W_SUB;
        step();
        s_valid = 1'b0;
        step();
        chk("ord_hold", 32'(obs_bundle()), 32'(B_AND));
        m_ready = 1'b1;
        step();
        chk("ord_second", 32'(obs_bundle()), 32'(B_SUB));
        step();
        chk("ord_end", 32'(m_valid), 32'd0);

        // Reset with main and skid both full and counter nonzero
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_instr = W_ORR;
        step();
        step();
        s_valid = 1'b0;
        chk("pre_rst_cnt", 32'(illegal_cnt), 32'd2);
        chk("pre_rst_rdy", 32'(s_ready), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_rdy", 32'(s_ready), 32'd1);
        chk("mid_rst_cnt", 32'(illegal_cnt), 32'd0);
        chk("mid_rst_bundle", 32'(obs_bundle()), 32'd0);
`else
        // Bypass: one held bundle blocks s_ready in the same cycle
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_instr = W_EOR;
        step();
        chk("byp_hold", 32'(obs_bundle()), 32'(B_EOR));
        chk("byp_rdy0", 32'(s_ready), 32'd0);
        s_instr = W_AND;
        step();
        chk("byp_no_accept", 32'(obs_bundle()), 32'(B_EOR));
        m_ready = 1'b1;
        #1;
        chk("byp_rdy1", 32'(s_ready), 32'd1);
        s_valid = 1'b0;
        step();
        chk("byp_end", 32'(m_valid), 32'd0);
`endif

        // 300 ORR words at full rate: counter saturates at 255
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_instr = W_ORR;
        for (int i = 1; i <= 300; i++) begin
            step();
            chk($sformatf("orr_bundle_%0d", i), 32'(obs_bundle()), 32'(B_ORR));
            chk($sformatf("orr_cnt_%0d", i), 32'(illegal_cnt), (i > 255) ? 32'd255 : 32'(i));
        end
        s_instr = W_ADD;
        step();
        s_valid = 1'b0;
        chk("sat_legal_bundle", 32'(obs_bundle()), 32'(B_ADD));
        chk("sat_legal_cnt", 32'(illegal_cnt), 32'd255);
        step();
        chk("final_idle", 32'(m_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
